// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle CPU control path:
// FSM states, opcodes, ALUOp, PC source and ALU B-source selects.
package cpu_ctrl_pkg;

  localparam int STATE_BITS = 4;

  typedef enum logic [STATE_BITS-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_WB_R     = 4'd3,
    S_EXEC_I   = 4'd4,
    S_WB_I     = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_MEM_WB   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_TRAP     = 4'd12
  } state_e;

  localparam logic [3:0] OP_AND_OR  = 4'b0000;
  localparam logic [3:0] OP_ADD_SUB = 4'b0001;
  localparam logic [3:0] OP_SHIFT   = 4'b0010;
  localparam logic [3:0] OP_LW      = 4'b0100;
  localparam logic [3:0] OP_SW      = 4'b0101;
  localparam logic [3:0] OP_BEQ     = 4'b0110;
  localparam logic [3:0] OP_J       = 4'b0111;
  localparam logic [3:0] OP_ADDI    = 4'b1001;
  localparam logic [3:0] OP_SUBI    = 4'b1010;
  localparam logic [3:0] OP_SLTI    = 4'b1011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_ONE  = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  typedef enum logic [2:0] {
    CLS_R,
    CLS_I,
    CLS_LW,
    CLS_SW,
    CLS_BEQ,
    CLS_J,
    CLS_ILLEGAL
  } op_class_e;

endpackage

// File: rtl/cu_opcode_class.sv
// Combinational opcode classifier feeding the DECODE
// and MEM_ADDR transitions of the control FSM.
module cu_opcode_class
  import cpu_ctrl_pkg::*;
(
  input  logic [3:0] i_opcode,
  output op_class_e  o_class
);

  always_comb begin
    o_class = CLS_ILLEGAL;
    unique case (1'b1)
      (i_opcode == OP_AND_OR),
      (i_opcode == OP_ADD_SUB): o_class = CLS_R;
      (i_opcode == OP_SHIFT),
      (i_opcode == OP_ADDI),
      (i_opcode == OP_SUBI),
      (i_opcode == OP_SLTI):    o_class = CLS_I;
      (i_opcode == OP_LW):      o_class = CLS_LW;
      (i_opcode == OP_SW):      o_class = CLS_SW;
      (i_opcode == OP_BEQ):     o_class = CLS_BEQ;
      (i_opcode == OP_J):       o_class = CLS_J;
      default:                  o_class = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Main control FSM of the 16-bit multicycle CPU (Moore).
// Define CU_ILLEGAL_TRAP_EN to trap illegal opcodes.
module multicycle_control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic [3:0]         opcode,
  input  logic               mem_ready,
  output logic [1:0]         ALUOp,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic [1:0]         PCSource,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegDst,
  output logic               RegWrite,
  output logic               MemtoReg,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic               instr_done,
  output logic [STATE_W-1:0] state_dbg
`ifdef CU_ILLEGAL_TRAP_EN
  ,
  output logic               illegal_op
`endif
);

  state_e    r_state;
  state_e    w_next;
  op_class_e w_class;

  cu_opcode_class u_cls (
    .i_opcode (opcode),
    .o_class  (w_class)
  );

  always_ff @(posedge Clock) begin
    if (Reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  assign state_dbg = Reset ? STATE_W'(S_FETCH)
                           : STATE_W'(r_state);

  always_comb begin
    w_next      = r_state;
    ALUOp       = ALUOP_ADD;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    PCSource    = PCSRC_ALU;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    MemtoReg    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_REG;
    instr_done  = 1'b0;
`ifdef CU_ILLEGAL_TRAP_EN
    illegal_op  = 1'b0;
`endif
    // Reset blanks every output, even mid-instruction
    if (!Reset) begin
      case (r_state)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = SRCB_ONE;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
          if (mem_ready) w_next = S_DECODE;
        end
        S_DECODE: begin
          ALUSrcB = SRCB_BOFF;
          unique case (w_class)
            CLS_R:   w_next = S_EXEC_R;
            CLS_I:   w_next = S_EXEC_I;
            CLS_LW,
            CLS_SW:  w_next = S_MEM_ADDR;
            CLS_BEQ: w_next = S_BRANCH;
            CLS_J:   w_next = S_JUMP;
`ifdef CU_ILLEGAL_TRAP_EN
            default: w_next = S_TRAP;
`else
            default: w_next = S_FETCH;
`endif
          endcase
        end
        S_EXEC_R: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_REG;
          ALUOp   = ALUOP_RTYPE;
          w_next  = S_WB_R;
        end
        S_WB_R: begin
          RegDst     = 1'b1;
          RegWrite   = 1'b1;
          instr_done = 1'b1;
          w_next     = S_FETCH;
        end
        S_EXEC_I: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
          ALUOp   = ALUOP_ITYPE;
          w_next  = S_WB_I;
        end
        S_WB_I: begin
          RegWrite   = 1'b1;
          instr_done = 1'b1;
          w_next     = S_FETCH;
        end
        S_MEM_ADDR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
          w_next  = (w_class == CLS_SW) ? S_MEM_WR
                                        : S_MEM_RD;
        end
        S_MEM_RD: begin
          IorD    = 1'b1;
          MemRead = 1'b1;
          if (mem_ready) w_next = S_MEM_WB;
        end
        S_MEM_WB: begin
          MemtoReg   = 1'b1;
          RegWrite   = 1'b1;
          instr_done = 1'b1;
          w_next     = S_FETCH;
        end
        S_MEM_WR: begin
          IorD       = 1'b1;
          MemWrite   = 1'b1;
          instr_done = mem_ready;
          if (mem_ready) w_next = S_FETCH;
        end
        S_BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUSrcB     = SRCB_REG;
          ALUOp       = ALUOP_SUB;
          PCWriteCond = 1'b1;
          PCSource    = PCSRC_ALUOUT;
          instr_done  = 1'b1;
          w_next      = S_FETCH;
        end
        S_JUMP: begin
          PCWrite    = 1'b1;
          PCSource   = PCSRC_JUMP;
          instr_done = 1'b1;
          w_next     = S_FETCH;
        end
`ifdef CU_ILLEGAL_TRAP_EN
        S_TRAP: begin
          illegal_op = 1'b1;
          w_next     = S_TRAP;
        end
`endif
        default: w_next = S_FETCH;
      endcase
    end
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Main control FSM of the 16-bit multicycle CPU; sits directly upstream of ALUControl.
- Steps each instruction through fetch/decode/execute/memory/writeback.
- Drives ALUOp[1:0] into ALUControl plus all datapath enables (PC, IR, memory, register file, ALU source muxes).
- Handshakes with instruction/data memory through mem_ready.

Parameters:
- STATE_W, 4, width of state register and state_dbg port.

Ports:
- Clock  input  1  system clock, rising edge
- Reset  input  1  synchronous, active-high reset
- opcode  input  4  IR[15:12], valid from DECODE onward
- mem_ready  input  1  memory completes the access this cycle
- ALUOp  output  2  00 add, 01 sub (BEQ), 10 R-format, 11 I-format
- PCWrite  output  1  unconditional PC load
- PCWriteCond  output  1  PC load if ALU zero (BEQ)
- PCSource  output  2  00 ALU result, 01 ALUOut, 10 jump target
- IorD  output  1  0 PC address, 1 ALUOut address
- MemRead  output  1  memory read request
- MemWrite  output  1  memory write request
- IRWrite  output  1  instruction register load
- RegDst  output  1  1 rd, 0 rt
- RegWrite  output  1  register file write
- MemtoReg  output  1  1 MDR, 0 ALUOut
- ALUSrcA  output  1  0 PC, 1 reg A
- ALUSrcB  output  2  00 reg B, 01 const 1, 10 sign-ext imm, 11 branch offset
- instr_done  output  1  one-cycle pulse on the last cycle of each instruction
- state_dbg  output  STATE_W  current state

Behaviour:
- Moore FSM; outputs decode from the state register only, except that memory/IR/PC strobes in memory states are qualified by mem_ready.
- Reset: state <= FETCH on the Clock edge with Reset=1. While Reset=1, all outputs are forced to 0 (state_dbg reads FETCH). Reset mid-instruction abandons it with no writes.
- Opcodes:
  - 0000/0001 R (AND/OR, ADD/SUB)
  - 0010 shift (SLL/SRA)
  - 0100 LW
  - 0101 SW
  - 0110 BEQ
  - 0111 J
  - 1001 ADDI
  - 1010 SUBI
  - 1011 SLTI
  - all others illegal
- FETCH:
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite and PCWrite assert only when mem_ready=1. Stay in FETCH while mem_ready=0; go to DECODE when 1.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target). Branch on opcode:
  - R -> EXEC_R
  - shift/ADDI/SUBI/SLTI -> EXEC_I
  - LW/SW -> MEM_ADDR
  - BEQ -> BRANCH
  - J -> JUMP
  - illegal -> FETCH
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> WB_R.
- WB_R: RegDst=1, RegWrite=1, MemtoReg=0, instr_done -> FETCH.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp=11 -> WB_I.
- WB_I: RegDst=0, RegWrite=1, MemtoReg=0, instr_done -> FETCH.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. LW -> MEM_RD; SW -> MEM_WR.
- MEM_RD: IorD=1, MemRead=1. Hold until mem_ready, then -> MEM_WB.
- MEM_WB: RegDst=0, MemtoReg=1, RegWrite=1, instr_done -> FETCH.
- MEM_WR: IorD=1, MemWrite=1, held until mem_ready. instr_done on the mem_ready cycle -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, instr_done -> FETCH.
- JUMP: PCWrite=1, PCSource=10, instr_done -> FETCH.
- Latency excluding memory wait cycles:
  - BEQ, J: 3 cycles
  - R, I, SW: 4 cycles
  - LW: 5 cycles
- Each wait cycle adds exactly 1 cycle.
- Unused state encodings -> FETCH with all outputs 0.
- MemRead and MemWrite are never both 1. RegWrite is never 1 in a memory-wait cycle.

Optional Feature:
- Macro: CU_ILLEGAL_TRAP_EN.
- Defined: adds output illegal_op (1 bit) and state TRAP. An illegal opcode in DECODE goes to TRAP. TRAP holds with all enables 0 and illegal_op=1 until Reset.
- Undefined: an illegal opcode is a NOP (DECODE -> FETCH, no instr_done), and the illegal_op port is absent.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - state encodings
  - opcode constants
  - ALUOp constants (00/01/10/11, shared with ALUControl)
  - PCSource and ALUSrcB encodings
- One sub-module, cu_opcode_class: combinational opcode -> class (R, I, LW, SW, BEQ, J, ILLEGAL) used by the DECODE transition.

Test Plan:
- Reset held 3 cycles during an LW in MEM_RD -> all outputs 0, state_dbg=FETCH, no RegWrite after release.
- ADD (opcode 0001), mem_ready=1 -> states FETCH, DECODE, EXEC_R, WB_R. ALUOp=10 in EXEC_R. RegWrite=1, RegDst=1 in cycle 4. instr_done in cycle 4 only.
- LW with mem_ready low for 2 cycles in MEM_RD -> 7 cycles total. MemRead=1, IorD=1 throughout the wait. RegWrite=1, MemtoReg=1 exactly once.
- BEQ (0110) -> 3 cycles. ALUOp=01, PCWriteCond=1, PCSource=01 in BRANCH. PCWrite=0.
- SLTI (1011) -> ALUOp=11, ALUSrcB=10 in EXEC_I. RegDst=0, RegWrite=1 in WB_I.
- Opcode 1111 -> with CU_ILLEGAL_TRAP_EN: illegal_op=1 and stuck until Reset. Without: returns to FETCH after 2 cycles, no writes.
